// File: rtl/vga_pkg.sv
// Display geometry, colour widths and packed colour type shared between the
// sync generator and the RGB output stage.
package vga_pkg;

  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int COLOUR_W      = 12;
  localparam int CHAN_W        = 4;
  localparam int POS_W         = 10;

  // Field order matches the {R, G, B} packing of colour_data.
  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '{r: '0, g: '0, b: '0};

endpackage

// File: rtl/active_area_check.sv
// Decides whether the current pixel position lies inside the visible window.
// Purely combinational; the caller registers the result path.
module active_area_check
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic             en,
  input  logic [POS_W-1:0] row,
  input  logic [POS_W-1:0] column,
  output logic             visible
);

  // One extra bit so a limit equal to 2**POS_W still compares correctly.
  localparam logic [POS_W:0] H_LIM = (POS_W+1)'(H_ACTIVE);
  localparam logic [POS_W:0] V_LIM = (POS_W+1)'(V_ACTIVE);

  // Visible only inside both active ranges while the sync generator says so.
  always_comb begin
    visible = en && ({1'b0, row} < V_LIM) && ({1'b0, column} < H_LIM);
  end

endmodule

// File: rtl/rgb_controller.sv
// RGB DAC drive stage: passes colour_data through to the DAC pins one clock
// later inside the visible window, and drives black everywhere else.
module rgb_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [POS_W-1:0]    row,
  input  logic [POS_W-1:0]    column,
  input  logic [COLOUR_W-1:0] colour_data,
  output logic [CHAN_W-1:0]   r,
  output logic [CHAN_W-1:0]   g,
  output logic [CHAN_W-1:0]   b
);

  logic visible;
  rgb_t pix_d;
  rgb_t pix_q;

  active_area_check #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_active_area_check (
    .en      (en),
    .row     (row),
    .column  (column),
    .visible (visible)
  );

  // Select the incoming colour or blanking for the next pixel.
  always_comb begin
    pix_d = RGB_BLACK;
    if (visible) begin
      pix_d = rgb_t'(colour_data);
    end
  end

  // All three channels share one register so they always change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= RGB_BLACK;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign r = pix_q.r;
  assign g = pix_q.g;
  assign b = pix_q.b;

endmodule

// File: tb/tb_rgb_controller.sv
// Directed bench for rgb_controller: drives inputs on the falling edge and
// samples outputs 1 ns after the rising edge.
module tb_rgb_controller;

  logic        clk;
  logic        rst;
  logic        en;
  logic [9:0]  row;
  logic [9:0]  column;
  logic [11:0] colour_data;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  int vectors;
  int miscompares;

  rgb_controller #(
    .H_ACTIVE (640),
    .V_ACTIVE (480)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .row         (row),
    .column      (column),
    .colour_data (colour_data),
    .r           (r),
    .g           (g),
    .b           (b)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Apply one set of inputs and advance past the next rising edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [9:0] row_v,
                      input logic [9:0] col_v, input logic [11:0] data_v);
    @(negedge clk);
    rst = rst_v;
    en = en_v;
    row = row_v;
    column = col_v;
    colour_data = data_v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 10'd200, 10'd300, 12'hF00);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_priority: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
  endtask

  task automatic test_release;
    step(1'b0, 1'b1, 10'd200, 10'd300, 12'hF00);
    vectors++;
    if ({r, g, b} !== 12'hF00) begin
      miscompares++;
      $display("FAIL release_red: got r=%h g=%h b=%h, want F 0 0", r, g, b);
    end
  endtask

  task automatic test_channels;
    step(1'b0, 1'b1, 10'd200, 10'd300, 12'h0F0);
    vectors++;
    if ({r, g, b} !== 12'h0F0) begin
      miscompares++;
      $display("FAIL green_only: got r=%h g=%h b=%h, want 0 F 0", r, g, b);
    end
    step(1'b0, 1'b1, 10'd200, 10'd300, 12'h00F);
    vectors++;
    if ({r, g, b} !== 12'h00F) begin
      miscompares++;
      $display("FAIL blue_only: got r=%h g=%h b=%h, want 0 0 F", r, g, b);
    end
    step(1'b0, 1'b1, 10'd10, 10'd20, 12'h5A3);
    vectors++;
    if ({r, g, b} !== 12'h5A3) begin
      miscompares++;
      $display("FAIL mixed_channels: got r=%h g=%h b=%h, want 5 A 3", r, g, b);
    end
  endtask

  task automatic test_enable;
    step(1'b0, 1'b0, 10'd200, 10'd300, 12'h0F0);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL en_low_blank: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
    step(1'b0, 1'b1, 10'd200, 10'd300, 12'h0F0);
    vectors++;
    if ({r, g, b} !== 12'h0F0) begin
      miscompares++;
      $display("FAIL en_high_again: got r=%h g=%h b=%h, want 0 F 0", r, g, b);
    end
  endtask

  task automatic test_boundary;
    step(1'b0, 1'b1, 10'd479, 10'd639, 12'hFFF);
    vectors++;
    if ({r, g, b} !== 12'hFFF) begin
      miscompares++;
      $display("FAIL last_pixel: got r=%h g=%h b=%h, want F F F", r, g, b);
    end
    step(1'b0, 1'b1, 10'd480, 10'd0, 12'hFFF);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL row_480: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
    step(1'b0, 1'b1, 10'd0, 10'd640, 12'hFFF);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL col_640: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
    step(1'b0, 1'b1, 10'd0, 10'd0, 12'h123);
    vectors++;
    if ({r, g, b} !== 12'h123) begin
      miscompares++;
      $display("FAIL first_pixel: got r=%h g=%h b=%h, want 1 2 3", r, g, b);
    end
    step(1'b0, 1'b1, 10'd1023, 10'd1023, 12'hFFF);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL max_position: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
    step(1'b0, 1'b0, 10'd479, 10'd639, 12'hFFF);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL corner_en_low: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
  endtask

  task automatic test_mid_reset;
    step(1'b0, 1'b1, 10'd100, 10'd100, 12'hABC);
    vectors++;
    if ({r, g, b} !== 12'hABC) begin
      miscompares++;
      $display("FAIL pre_reset_abc: got r=%h g=%h b=%h, want A B C", r, g, b);
    end
    step(1'b1, 1'b1, 10'd100, 10'd101, 12'hABC);
    vectors++;
    if ({r, g, b} !== 12'h000) begin
      miscompares++;
      $display("FAIL mid_reset_blank: got r=%h g=%h b=%h, want 0 0 0", r, g, b);
    end
    step(1'b0, 1'b1, 10'd100, 10'd102, 12'hABC);
    vectors++;
    if ({r, g, b} !== 12'hABC) begin
      miscompares++;
      $display("FAIL post_reset_abc: got r=%h g=%h b=%h, want A B C", r, g, b);
    end
  endtask

  // Inputs changed between edges must not reach the outputs until the next edge.
  task automatic test_hold;
    step(1'b0, 1'b1, 10'd50, 10'd60, 12'h321);
    @(negedge clk);
    colour_data = 12'h9E7;
    #5;
    vectors++;
    if ({r, g, b} !== 12'h321) begin
      miscompares++;
      $display("FAIL hold_mid_cycle: got r=%h g=%h b=%h, want 3 2 1", r, g, b);
    end
    en = 1'b0;
    #5;
    vectors++;
    if ({r, g, b} !== 12'h321) begin
      miscompares++;
      $display("FAIL hold_en_drop: got r=%h g=%h b=%h, want 3 2 1", r, g, b);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if ({r, g, b} !== 12'h9E7) begin
      miscompares++;
      $display("FAIL hold_next_edge: got r=%h g=%h b=%h, want 9 E 7", r, g, b);
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] seq [4];
    seq[0] = 12'h111;
    seq[1] = 12'hF0F;
    seq[2] = 12'h000;
    seq[3] = 12'hC3A;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 10'd300, 10'(i + 400), seq[i]);
      vectors++;
      if ({r, g, b} !== seq[i]) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got %h, want %h", i, {r, g, b}, seq[i]);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    en = 1'b0;
    row = '0;
    column = '0;
    colour_data = '0;
    test_reset();
    test_release();
    test_channels();
    test_enable();
    test_boundary();
    test_mid_reset();
    test_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
